// File: rtl/vga_framebuffer_reader.sv
// VGA scan-out of the displayed SRAM framebuffer: timing generator, read prefetch and pixel FIFO.
// Optional VGA_TEST_PATTERN_EN adds a testPattern input that replaces visible RGB with colour bars.
module vga_framebuffer_reader #(
  parameter int H_VISIBLE  = 800,
  parameter int H_FRONT    = 56,
  parameter int H_SYNC     = 120,
  parameter int H_BACK     = 64,
  parameter int V_VISIBLE  = 600,
  parameter int V_FRONT    = 37,
  parameter int V_SYNC     = 6,
  parameter int V_BACK     = 23,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] baseAddress,
  output logic              paintDone,
  output logic [ADDR_W-1:0] ramAddress,
  output logic              ramRead,
  input  logic              ramGrant,
  input  logic              ramDataValid,
  input  logic [31:0]       ramData,
  output logic              vgaHsync,
  output logic              vgaVsync,
  output logic              vgaDe,
  output logic [2:0]        vgaRed,
  output logic [2:0]        vgaGreen,
  output logic [2:0]        vgaBlue,
  output logic              underrun
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic              testPattern
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);
  localparam int PIXELS  = H_VISIBLE * V_VISIBLE;
  localparam int FCW     = $clog2(PIXELS + 1);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);

  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_VIS    = HCW'(H_VISIBLE);
  localparam logic [HCW-1:0] HS_FIRST = HCW'(H_VISIBLE + H_FRONT);
  localparam logic [HCW-1:0] HS_LAST  = HCW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_VIS    = VCW'(V_VISIBLE);
  localparam logic [VCW-1:0] V_VIS_M1 = VCW'(V_VISIBLE - 1);
  localparam logic [VCW-1:0] VS_FIRST = VCW'(V_VISIBLE + V_FRONT);
  localparam logic [VCW-1:0] VS_LAST  = VCW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [HCW-1:0]    r_hcount;
  logic [VCW-1:0]    r_vcount;
  logic              r_active;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [FCW-1:0]    r_fetch_count;
  logic [FCW-1:0]    r_drop;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_fifo_count;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [8:0]        r_mem [FIFO_DEPTH];
  logic              r_hsync, r_vsync, r_de, r_paint_done, r_underrun;
  logic [8:0]        r_rgb;

  logic              w_visible, w_hsync, w_vsync, w_latch, w_empty;
  logic              w_pop_slot, w_pop, w_skip, w_discard, w_push, w_grant;
  logic [CW:0]       w_occupancy;
  logic [CW-1:0]     w_outstanding_next;
  logic [8:0]        w_pixel, w_rgb_next;
  logic              w_unused;

  assign w_unused  = &{1'b0, ramData[31:9]};
  assign w_visible = (r_hcount < H_VIS) && (r_vcount < V_VIS);
  assign w_hsync   = (r_hcount >= HS_FIRST) && (r_hcount <= HS_LAST);
  assign w_vsync   = (r_vcount >= VS_FIRST) && (r_vcount <= VS_LAST);
  // Start of the last back-porch line: one full line of lead time to prefill the FIFO.
  assign w_latch   = (r_hcount == '0) && (r_vcount == V_LAST);
  assign w_empty   = (r_fifo_count == '0);

  // Before the first latch after reset nothing is fetched, so the frame is black without underrun.
  assign w_pop_slot = w_visible && r_active;
  assign w_pop      = w_pop_slot && !w_empty;
  assign w_skip     = w_pop_slot && w_empty;
  // A word arriving while its own pixel is being skipped is dropped on the spot.
  assign w_discard  = ramDataValid && ((r_drop != '0) || w_skip);
  assign w_push     = ramDataValid && !w_discard;

  assign w_occupancy = {1'b0, r_fifo_count} + {1'b0, r_outstanding};
  assign ramRead     = r_active && (r_fetch_count < FCW'(PIXELS)) &&
                       (w_occupancy < (CW+1)'(FIFO_DEPTH));
  assign ramAddress  = r_fetch_addr;
  assign w_grant     = ramRead && ramGrant;
  assign w_outstanding_next = r_outstanding + CW'(w_grant) - CW'(ramDataValid);

  assign w_pixel = r_mem[r_rd_ptr];

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_VISIBLE / 8;
  logic [2:0] w_bar;
  assign w_bar = 3'(r_hcount / HCW'(BAR_W));
  always_comb begin
    w_rgb_next = '0;
    if (w_visible && testPattern)
      w_rgb_next = {{3{w_bar[2]}}, {3{w_bar[1]}}, {3{w_bar[0]}}};
    else if (w_pop)
      w_rgb_next = w_pixel;
  end
`else
  always_comb begin
    w_rgb_next = '0;
    if (w_pop)
      w_rgb_next = w_pixel;
  end
`endif

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= ramData[8:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_active      <= 1'b0;
      r_fetch_addr  <= '0;
      r_fetch_count <= '0;
      r_drop        <= '0;
      r_outstanding <= '0;
      r_fifo_count  <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_paint_done  <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      if (r_hcount == H_LAST) begin
        r_hcount <= '0;
        r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
      end else begin
        r_hcount <= r_hcount + 1'b1;
      end

      r_hsync      <= w_hsync;
      r_vsync      <= w_vsync;
      r_de         <= w_visible;
      r_rgb        <= w_rgb_next;
      r_paint_done <= (r_hcount == H_LAST) && (r_vcount == V_VIS_M1);
      r_outstanding <= w_outstanding_next;

      if (w_latch) begin
        // Reads still in flight belong to the previous frame and are discarded on return.
        r_active      <= 1'b1;
        r_fetch_addr  <= baseAddress;
        r_fetch_count <= '0;
        r_fifo_count  <= '0;
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_drop        <= FCW'(w_outstanding_next);
        r_underrun    <= 1'b0;
      end else begin
        if (w_grant) begin
          r_fetch_addr  <= r_fetch_addr + 1'b1;
          r_fetch_count <= r_fetch_count + 1'b1;
        end
        if (w_push)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + 1'b1;
        r_fifo_count <= r_fifo_count + CW'(w_push) - CW'(w_pop);
        r_drop       <= r_drop + FCW'(w_skip) - FCW'(w_discard);
        if (w_skip)
          r_underrun <= 1'b1;
      end
    end
  end

  assign vgaHsync  = r_hsync;
  assign vgaVsync  = r_vsync;
  assign vgaDe     = r_de;
  assign vgaRed    = r_rgb[8:6];
  assign vgaGreen  = r_rgb[5:3];
  assign vgaBlue   = r_rgb[2:0];
  assign paintDone = r_paint_done;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Bench for vga_framebuffer_reader on a shrunken raster (48x14 total, 32x8 visible) with a zero-latency SRAM model.
module tb_vga_framebuffer_reader;

  localparam int HV = 32, HF = 4, HS = 6, HB = 6;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME  = HT * VT;
  localparam int PIXELS = HV * VV;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] baseAddress;
  logic        paintDone;
  logic [19:0] ramAddress;
  logic        ramRead;
  logic        ramGrant;
  logic        ramDataValid = 1'b0;
  logic [31:0] ramData = '0;
  logic        vgaHsync, vgaVsync, vgaDe, underrun;
  logic [2:0]  vgaRed, vgaGreen, vgaBlue;

  always #10 clk = ~clk;

  vga_framebuffer_reader #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .FIFO_DEPTH(16), .ADDR_W(20)
  ) dut (
    .clk(clk), .rst(rst), .baseAddress(baseAddress), .paintDone(paintDone),
    .ramAddress(ramAddress), .ramRead(ramRead), .ramGrant(ramGrant),
    .ramDataValid(ramDataValid), .ramData(ramData),
    .vgaHsync(vgaHsync), .vgaVsync(vgaVsync), .vgaDe(vgaDe),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue), .underrun(underrun)
  );

  // SRAM: a transfer accepted at one edge returns word = address right after the next edge.
  logic        pend_v = 1'b0;
  logic [19:0] pend_a = '0;
  always @(negedge clk) begin
    pend_v = ramRead && ramGrant && !rst;
    pend_a = ramAddress;
  end
  always @(posedge clk) begin
    #1;
    ramDataValid = pend_v;
    ramData      = {12'd0, pend_a};
  end

  typedef struct {
    int          h;
    int          v;
    logic [11:0] exp;   // {de, hsync, vsync, rgb[8:0]}
  } vec_t;
  vec_t vec [13];

  int checks = 0, errors = 0;
  int pos = -2, oh = -1, ov = -1;
  int pix_bad, black_cnt, read_cnt, paint_cnt, tim_bad = 0;
  int grant_frame = 0, last_grants = -1;
  bit strict = 1'b1, disp_ok = 1'b0, pend_ok = 1'b0;
  logic [19:0] frame_base = '0, pend_base = '0;

  function automatic logic [8:0] rgb();
    return {vgaRed, vgaGreen, vgaBlue};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    pix_bad = 0; black_cnt = 0; read_cnt = 0; paint_cnt = 0;
  endtask

  // Advance one clock; outputs then reflect raster position pos, counters hold pos+1.
  task automatic tick();
    int ch, cv, a;
    bit e_de, e_hs, e_vs;
    logic [8:0] expw;
    @(posedge clk);
    #1;
    pos++;
    oh = (pos >= 0) ? pos % HT : -1;
    ov = (pos >= 0) ? (pos / HT) % VT : -1;
    ch = (pos + 1) % HT;
    cv = ((pos + 1) / HT) % VT;
    e_de = (pos >= 0) && oh < HV && ov < VV;
    e_hs = (pos >= 0) && oh >= HV + HF && oh < HV + HF + HS;
    e_vs = (pos >= 0) && ov >= VV + VF && ov < VV + VF + VS;
    if ({vgaDe, vgaHsync, vgaVsync} != {e_de, e_hs, e_vs}) tim_bad++;
    if (paintDone != (ch == 0 && cv == VV)) tim_bad++;
    paint_cnt += int'(paintDone);
    read_cnt  += int'(ramRead);
    grant_frame += int'(ramRead && ramGrant);
    if (ch == 0 && cv == VT - 1) begin
      pend_base   = baseAddress;
      pend_ok     = 1'b1;
      last_grants = grant_frame;
      grant_frame = 0;
    end
    if (pos >= 0 && oh == 0 && ov == 0 && pend_ok) begin
      frame_base = pend_base;
      disp_ok    = 1'b1;
      pend_ok    = 1'b0;
    end
    if (e_de) begin
      a = int'(frame_base) + ov * HV + oh;
      expw = disp_ok ? 9'(a) : 9'd0;
      if (strict) begin
        if (rgb() != expw) pix_bad++;
      end else begin
        if (rgb() != 9'd0 && rgb() != expw) pix_bad++;
        if (rgb() == 9'd0 && expw != 9'd0) black_cnt++;
      end
    end else if (rgb() != 9'd0) begin
      tim_bad++;
    end
  endtask

  task automatic wait_out(input int h, input int v);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(oh == h && ov == v) && n < FRAME + 2);
    if (!(oh == h && ov == v)) begin
      errors++;
      checks++;
      $display("FAIL wait_out(%0d,%0d): timed out after %0d cycles", h, v, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pos = -2;
    disp_ok = 1'b0;
    pend_ok = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic int outputs_packed();
    return int'({paintDone, ramRead, underrun, vgaDe, vgaHsync, vgaVsync, rgb(), |ramAddress});
  endfunction

  initial begin
    vec[0]  = '{0, 0, 12'h800};
    vec[1]  = '{5, 1, 12'h825};
    vec[2]  = '{32, 2, 12'h000};
    vec[3]  = '{35, 2, 12'h000};
    vec[4]  = '{36, 2, 12'h400};
    vec[5]  = '{41, 2, 12'h400};
    vec[6]  = '{42, 2, 12'h000};
    vec[7]  = '{16, 5, 12'h8B0};
    vec[8]  = '{31, 7, 12'h8FF};
    vec[9]  = '{0, 9, 12'h000};
    vec[10] = '{0, 10, 12'h200};
    vec[11] = '{47, 11, 12'h200};
    vec[12] = '{0, 12, 12'h000};

    rst = 1'b1;
    baseAddress = 20'h00000;
    ramGrant = 1'b1;
    #3;
    do_reset();
    check("reset_outputs", outputs_packed(), 0);

    // First frame after reset: black, no fetch until the latch line.
    clear_stats();
    wait_out(HT - 1, VT - 2);
    check("no_fetch_before_latch", read_cnt, 0);
    check("black_first_frame", pix_bad, 0);
    check("no_underrun_before_latch", int'(underrun), 0);
    wait_out(HT - 1, VT - 1);
    check("fetch_after_latch", int'(read_cnt > 0), 1);
    clear_stats();

    for (int i = 0; i < 13; i++) begin
      wait_out(vec[i].h, vec[i].v);
      check($sformatf("vec%0d(%0d,%0d)", i, vec[i].h, vec[i].v),
            int'({vgaDe, vgaHsync, vgaVsync, rgb()}), int'(vec[i].exp));
    end
    wait_out(HT - 1, VT - 2);
    check("frame1_underrun", int'(underrun), 0);
    wait_out(HT - 1, VT - 1);
    check("frame1_pixels", pix_bad, 0);
    check("paint_once", paint_cnt, 1);
    check("grants_per_frame", last_grants, PIXELS);
    clear_stats();

    // Base changes mid-frame: this frame still shows the old buffer.
    wait_out(10, 3);
    baseAddress = 20'h75300;
    wait_out(HT - 1, VT - 1);
    check("frame2_old_base", pix_bad, 0);
    clear_stats();

    tick();
    check("new_base_pixel00", int'(rgb()), 9'h100);
    wait_out(HT - 1, VT - 1);
    check("frame3_new_base", pix_bad, 0);
    clear_stats();
    strict = 1'b0;

    // SRAM stall of 24 clocks mid line 3.
    wait_out(3, 3);
    ramGrant = 1'b0;
    repeat (24) tick();
    ramGrant = 1'b1;
    check("stalled_pixel_black", int'(rgb()), 0);
    wait_out(5, 6);
    check("realigned_pixel", int'(rgb()), 9'h1C5);
    wait_out(40, 12);
    check("underrun_set", int'(underrun), 1);
    wait_out(HT - 1, VT - 1);
    check("stall_alignment", pix_bad, 0);
    check("stall_black_pixels", int'(black_cnt >= 8), 1);
    strict = 1'b1;
    clear_stats();

    tick();
    check("underrun_cleared", int'(underrun), 0);

    // Reset in the middle of the visible area.
    wait_out(15, 4);
    do_reset();
    check("midreset_outputs", outputs_packed(), 0);
    clear_stats();
    wait_out(HT - 1, VT - 2);
    check("no_fetch_after_reset", read_cnt, 0);
    check("black_after_reset", pix_bad, 0);
    check("no_underrun_after_reset", int'(underrun), 0);
    wait_out(HT - 1, VT - 1);
    clear_stats();
    wait_out(HT - 1, VT - 1);
    check("post_reset_frame", pix_bad, 0);
    check("post_reset_grants", last_grants, PIXELS);
    check("post_reset_underrun", int'(underrun), 0);
    check("sync_timing", tim_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
